// File: rtl/dcache_ctrl.sv
// dcache_ctrl: fixed-latency data-cache controller; define DCACHE_ALIGN_CHK_EN to trap misaligned word writes
module dcache_ctrl #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dcache_en,
    input  logic [1:0]  dcache_we,
    input  logic [15:0] dcache_addr,
    input  logic [15:0] dcache_din,
    output logic        dcache_r,
    output logic [15:0] dcache_dout,
    output logic        dcache_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t               state, state_nx;
    logic [3:0]           cnt, cnt_nx;
    logic [1:0]           we_q, cur_we;
    logic [15:0]          addr_q, din_q, cur_addr, cur_din;
    logic [ADDR_BITS-1:0] idx;
    logic [15:0]          mem [2**ADDR_BITS];
    logic                 capture, enter_done, misal, wr_en, unused_addr;

    // with LATENCY=1 the access completes on the capture edge, so IDLE uses the live inputs
    assign cur_we      = state == IDLE ? dcache_we   : we_q;
    assign cur_addr    = state == IDLE ? dcache_addr : addr_q;
    assign cur_din     = state == IDLE ? dcache_din  : din_q;
    assign idx         = cur_addr[ADDR_BITS:1];
    assign unused_addr = ^cur_addr;

    // state and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // next state: accept in IDLE, count down in BUSY (abort when en drops), DONE lasts one cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (dcache_en) begin
                state_nx = LATENCY == 1 ? DONE : BUSY;
                cnt_nx   = 4'(LATENCY - 1);
            end
            BUSY: begin
                state_nx = !dcache_en ? IDLE : cnt == 4'd1 ? DONE : BUSY;
                cnt_nx   = (!dcache_en || cnt == 4'd1) ? 4'd0 : cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // control outputs: capture strobe, completion strobe and write commit
    always_comb begin
        capture    = state == IDLE && dcache_en;
        enter_done = state != DONE && state_nx == DONE;
        wr_en      = rst_n && enter_done && |cur_we && !misal;
    end

    // captured request, frozen while the access is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= '0;
            addr_q <= '0;
            din_q  <= '0;
        end else if (capture) begin
            we_q   <= dcache_we;
            addr_q <= dcache_addr;
            din_q  <= dcache_din;
        end
    end

    // completion pulse and read word (pre-write value) on the edge entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcache_r    <= 1'b0;
            dcache_dout <= '0;
        end else begin
            dcache_r <= enter_done;
            if (enter_done) dcache_dout <= mem[idx];
        end
    end

`ifdef DCACHE_ALIGN_CHK_EN
    assign misal = &cur_we & cur_addr[0];

    // misaligned word-write flag, pulsed alongside dcache_r
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dcache_err <= 1'b0;
        else        dcache_err <= enter_done && misal;
    end
`else
    assign misal      = 1'b0;
    assign dcache_err = 1'b0;
`endif

    // data array, byte-lane writes, never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (cur_we[0]) mem[idx][7:0]  <= cur_din[7:0];
            if (cur_we[1]) mem[idx][15:8] <= cur_din[15:8];
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized and directed checks of dcache_ctrl (LATENCY 4 and 1) against a behavioural model
module tb_dcache_ctrl;
`ifdef DCACHE_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam int LATS[2] = '{4, 1};

    logic             clk, rst_n;
    logic [1:0]       en, r_o, err_o;
    logic [1:0][1:0]  we;
    logic [1:0][15:0] addr, din, dout_o;
    int               checks = 0, fails = 0, cyc = 0;
    bit               go = 0;

    dcache_ctrl #(.LATENCY(4), .ADDR_BITS(12)) u0 (
        .clk(clk), .rst_n(rst_n), .dcache_en(en[0]), .dcache_we(we[0]),
        .dcache_addr(addr[0]), .dcache_din(din[0]), .dcache_r(r_o[0]),
        .dcache_dout(dout_o[0]), .dcache_err(err_o[0]));
    dcache_ctrl #(.LATENCY(1), .ADDR_BITS(12)) u1 (
        .clk(clk), .rst_n(rst_n), .dcache_en(en[1]), .dcache_we(we[1]),
        .dcache_addr(addr[1]), .dcache_din(din[1]), .dcache_r(r_o[1]),
        .dcache_dout(dout_o[1]), .dcache_err(err_o[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // behavioural model: a pending request completes LATENCY edges after the edge that sees it in IDLE
    logic [15:0] rm [2][4096];
    logic [1:0]  kn [2][4096];
    bit          pend[2], dl[2], xdv[2];
    int          left[2];
    logic [1:0]  cw[2];
    logic [15:0] ca[2], cd[2], xd[2];
    logic        xr[2], xerr[2];
    bit          fin, bad;
    int          ix;

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pend[k] = 0; dl[k] = 0; xr[k] = 0; xerr[k] = 0; xd[k] = '0; xdv[k] = 1;
            end else begin
                fin = 0; xr[k] = 0; xerr[k] = 0;
                if (pend[k]) begin
                    if (!en[k]) pend[k] = 0;
                    else begin left[k]--; fin = left[k] == 0; end
                end else if (!dl[k] && en[k]) begin
                    cw[k] = we[k]; ca[k] = addr[k]; cd[k] = din[k];
                    left[k] = LATS[k] - 1;
                    fin = left[k] == 0;
                    pend[k] = !fin;
                end
                dl[k] = fin;
                if (fin) begin
                    pend[k] = 0;
                    ix = int'(ca[k][12:1]);
                    xr[k] = 1;
                    xd[k] = rm[k][ix];
                    xdv[k] = kn[k][ix] == 2'b11;
                    bad = ALIGN && cw[k] == 2'b11 && ca[k][0];
                    xerr[k] = bad;
                    if (!bad && cw[k][0]) begin rm[k][ix][7:0]  = cd[k][7:0];  kn[k][ix][0] = 1; end
                    if (!bad && cw[k][1]) begin rm[k][ix][15:8] = cd[k][15:8]; kn[k][ix][1] = 1; end
                end
            end
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (go) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (r_o[k] !== xr[k] || err_o[k] !== xerr[k] || (xdv[k] && dout_o[k] !== xd[k])) begin
                    fails++;
                    $display("FAIL model[%0d] cyc=%0d: got r=%b err=%b dout=%h, expected r=%b err=%b dout=%h",
                             k, cyc, r_o[k], err_o[k], dout_o[k], xr[k], xerr[k], xd[k]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    bit lastd[2];
    int rcyc[2];

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
        lastd[0] = 0; lastd[1] = 0;
    endtask

    // one MEM-stage access; lat is measured from the edge that accepts it, -1 if no completion seen
    task automatic acc(input int k, input logic [1:0] w, input logic [15:0] a, input logic [15:0] d,
                       input int drop_at, output logic [15:0] got, output logic gerr, output int lat);
        int skip;
        skip = lastd[k] ? 1 : 0;
        en[k] = 1'b1; we[k] = w; addr[k] = a; din[k] = d;
        lat = -1; got = '0; gerr = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (r_o[k] && lat < 0) begin
                lat = n - skip; got = dout_o[k]; gerr = err_o[k]; rcyc[k] = cyc;
                en[k] = 1'b0;
                break;
            end
            if (drop_at > 0 && n == drop_at + skip) en[k] = 1'b0;
        end
        if (drop_at == 0) chk("completion", lat > 0 ? 1 : 0, 1);
        lastd[k] = lat > 0;
        if (lat < 0) lastd[0] = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] g, prev;
        logic        ge;
        int          lat, r1, j, drop, gap;
        int          pool[6] = '{0, 1, 2, 3, 12'hFFF, 12'h7FF};
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4096; i++) kn[k][i] = 2'b00;
        en = '0; we = '0; addr = '0; din = '0; rst_n = 1'b0;
        @(posedge clk);
        go = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_r0", int'(r_o[0]), 0);
        chk("rst_dout0", int'(dout_o[0]), 0);
        chk("rst_err0", int'(err_o[0]), 0);
        chk("rst_r1", int'(r_o[1]), 0);
        chk("rst_dout1", int'(dout_o[1]), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(1);

        acc(0, 2'b11, 16'h4000, 16'hA1B2, 0, g, ge, lat);
        chk("wr_latency", lat, 4);
        acc(0, 2'b00, 16'h4000, 16'h0000, 0, g, ge, lat);
        chk("rd_latency", lat, 4);
        chk("rd_A1B2", int'(g), 16'hA1B2);

        acc(0, 2'b11, 16'h4000, 16'h1234, 0, g, ge, lat);
        acc(0, 2'b01, 16'h4000, 16'h005A, 0, g, ge, lat);
        acc(0, 2'b10, 16'h4001, 16'h5A00, 0, g, ge, lat);
        acc(0, 2'b00, 16'h4000, 16'h0000, 0, g, ge, lat);
        chk("byte_lanes", int'(g), 16'h5A5A);

        idle(1);
        acc(0, 2'b00, 16'h4002, 16'h0000, 2, g, ge, lat);
        chk("abort_no_r", lat, -1);
        chk("abort_dout", int'(dout_o[0]), 16'h5A5A);
        acc(0, 2'b00, 16'h4000, 16'h0000, 0, g, ge, lat);
        chk("after_abort_lat", lat, 4);

        acc(0, 2'b11, 16'h2000, 16'hBEEF, 0, g, ge, lat);
        acc(0, 2'b00, 16'h0000, 16'h0000, 0, g, ge, lat);
        chk("wrap", int'(g), 16'hBEEF);

        acc(0, 2'b11, 16'h4000, 16'h1234, 0, g, ge, lat);
        acc(0, 2'b11, 16'h4001, 16'h9999, 0, g, ge, lat);
        chk("misalign_err", int'(ge), int'(ALIGN));
        acc(0, 2'b00, 16'h4000, 16'h0000, 0, g, ge, lat);
        prev = ALIGN ? 16'h1234 : 16'h9999;
        chk("misalign_data", int'(g), int'(prev));

        idle(1);
        en[0] = 1'b1; we[0] = 2'b11; addr[0] = 16'h4000; din[0] = 16'h7777;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0; en[0] = 1'b0;
        #1 chk("midreset_dout", int'(dout_o[0]), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        acc(0, 2'b00, 16'h4000, 16'h0000, 0, g, ge, lat);
        chk("midreset_nowrite", int'(g), int'(prev));

        acc(1, 2'b11, 16'h000A, 16'h1111, 0, g, ge, lat);
        acc(1, 2'b11, 16'h000C, 16'h2222, 0, g, ge, lat);
        idle(1);
        acc(1, 2'b00, 16'h000A, 16'h0000, 0, g, ge, lat);
        chk("l1_lat", lat, 1);
        chk("l1_rd0", int'(g), 16'h1111);
        r1 = rcyc[1];
        acc(1, 2'b00, 16'h000C, 16'h0000, 0, g, ge, lat);
        chk("l1_spacing", rcyc[1] - r1, 2);
        chk("l1_rd1", int'(g), 16'h2222);

        for (int k = 0; k < 2; k++) begin
            idle(1);
            for (int i = 0; i < 6; i++)
                acc(k, 2'b11, {3'd0, 12'(pool[i]), 1'b0}, 16'($urandom), 0, g, ge, lat);
            for (int i = 0; i < 80; i++) begin
                j = $urandom_range(0, 5);
                drop = (k == 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
                acc(k, 2'($urandom_range(0, 3)),
                    {3'($urandom_range(0, 7)), 12'(pool[j]), 1'($urandom_range(0, 1))},
                    16'($urandom), drop, g, ge, lat);
                chk(drop > 0 ? "rand_abort" : "rand_latency", lat, drop > 0 ? -1 : LATS[k]);
                gap = $urandom_range(0, 2);
                if (gap > 0) idle(gap);
            end
        end
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4: clock cycles from request acceptance to dcache_r pulse; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BITS, default 12: word-index width; the array holds 2^ADDR_BITS 16-bit words.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port dcache_en, input, 1: MEM-stage access request, held until dcache_r.
REQ-006 SHALL have port dcache_we, input, 2: byte-lane write enables; 00 = read, 01 = low byte, 10 = high byte, 11 = word.
REQ-007 SHALL have port dcache_addr, input, 16: byte address.
REQ-008 SHALL have port dcache_din, input, 16: write data, already lane-aligned by MEM.
REQ-009 SHALL have port dcache_r, output, 1: access complete, registered.
REQ-010 SHALL have port dcache_dout, output, 16: read word, registered.
REQ-011 SHALL have port dcache_err, output, 1: misaligned word-write flag (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE with dcache_en=1 SHALL capture addr/we/din and go to BUSY with counter=LATENCY-1. If LATENCY=1, it SHALL go directly to DONE.
REQ-014 BUSY SHALL decrement the counter each cycle and enter DONE on the cycle after the counter reaches 1. Result: dcache_r rises exactly LATENCY cycles after the acceptance edge.
REQ-015 DONE SHALL assert dcache_r=1 for exactly one cycle, then return to IDLE. DONE SHALL NOT accept a new request.
REQ-016 dcache_r SHALL be 0 in IDLE and BUSY.
REQ-017 Word index SHALL be addr[ADDR_BITS:1]. Higher address bits SHALL be ignored, so accesses wrap modulo the array size.
REQ-018 A write SHALL commit on the edge entering DONE. Only lanes with captured we bit set SHALL be updated (we[0] updates bits 7:0, we[1] updates bits 15:8).
REQ-019 On the edge entering DONE, dcache_dout SHALL load the array word at the captured index. For writes this is the pre-write value. dcache_dout SHALL hold until the next DONE entry.
REQ-020 Changes to addr/we/din during BUSY SHALL be ignored; the captured values are used.
REQ-021 If dcache_en=0 in any BUSY cycle (pipeline flush), the FSM SHALL abort to IDLE next cycle. No write SHALL commit, and dcache_r and dcache_dout SHALL stay unchanged.
REQ-022 Back-to-back requests SHALL be served: a request seen in IDLE the cycle after DONE is a new access. Minimum spacing between dcache_r pulses is LATENCY+1 cycles.
REQ-023 The read port SHALL have no byte selection; MEM performs lane select and sign extension.

Reset
REQ-024 While rst_n=0, state SHALL be IDLE, counter 0, dcache_r 0, dcache_dout 16'h0000, dcache_err 0, and the captured registers 0.
REQ-025 Reset asserted mid-BUSY SHALL abort the access with no write committed.
REQ-026 Array contents SHALL NOT be reset.

Configuration
REQ-027 Macro DCACHE_ALIGN_CHK_EN defined:
  - A captured we=11 with addr[0]=1 SHALL suppress the write.
  - dcache_err SHALL pulse together with dcache_r.
  - dcache_dout SHALL still load normally.
REQ-028 Macro DCACHE_ALIGN_CHK_EN undefined:
  - dcache_err SHALL be tied to 0.
  - Misaligned word writes SHALL commit to addr[ADDR_BITS:1].

Verification
REQ-029 Reset, LATENCY=4: word write x4000 <- A1B2 with en held, then read x4000. Required: dcache_r high exactly 4 cycles after each acceptance; read dout=A1B2.
REQ-030 Starting from word x1234, byte write we=01 din=005A to x4000, then we=10 din=5A00 to x4001, then read x4000. Required: dout=5A5A.
REQ-031 Read issued, then en dropped in the 2nd BUSY cycle. Required: no dcache_r pulse, prior dout unchanged, FSM back in IDLE; a following read still completes in 4 cycles.
REQ-032 With ADDR_BITS=12, write x2000 <- BEEF, then read x0000. Required: dout=BEEF (wrap).
REQ-033 LATENCY=1 back-to-back reads of two addresses. Required: dcache_r pulses 2 cycles apart with correct dout each time.
REQ-034 With DCACHE_ALIGN_CHK_EN defined: word write to x4001 over old data 1234. Required: dcache_err=1 with dcache_r, and a later read of x4000 gives 1234. Without the macro: err=0, and the read gives the written data.
